// File: rtl/l2_cache_dm.sv
// Direct-mapped, write-back, write-allocate L2 cache between the L1 line interface
// and a 128-bit line memory; one outstanding request at a time.
module l2_cache_dm #(
  parameter int ENTRYNUM = 64,
  parameter int IDXLEN   = 6,
  parameter int TAGLEN   = 22
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         l1_read,
  input  logic         l1_write,
  input  logic [29:0]  l1_addr,
  input  logic [127:0] l1_wdata,
  output logic [127:0] l1_rdata,
  output logic         l1_ready,
  output logic         l1_stall,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready,
  output logic [15:0]  hit_cnt,
  output logic [15:0]  miss_cnt
);

  typedef enum logic [1:0] {IDLE, WB, FETCH, RESP} state_t;

  state_t       state_q, state_d;
  logic [127:0] l1_rdata_q, l1_rdata_d;
  logic         l1_ready_q, l1_ready_d;
  logic         mem_read_q, mem_read_d;
  logic         mem_write_q, mem_write_d;
  logic [27:0]  mem_addr_q, mem_addr_d;
  logic [127:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]  hit_cnt_q, hit_cnt_d;
  logic [15:0]  miss_cnt_q, miss_cnt_d;

  logic              valid_q [ENTRYNUM];
  logic              dirty_q [ENTRYNUM];
  logic [TAGLEN-1:0] tag_q   [ENTRYNUM];
  logic [127:0]      data_q  [ENTRYNUM];

  logic [IDXLEN-1:0] idx;
  logic [TAGLEN-1:0] req_tag;
  logic              hit, victim_dirty;
  logic              line_we, line_dirty, dirty_clr;
  logic [127:0]      line_data;
  logic              addr_lsb_unused;

  assign idx             = l1_addr[IDXLEN+1:2];
  assign req_tag         = l1_addr[29:IDXLEN+2];
  assign addr_lsb_unused = ^l1_addr[1:0];
  assign hit             = valid_q[idx] && (tag_q[idx] == req_tag);
  assign victim_dirty    = valid_q[idx] && dirty_q[idx];

  always_comb begin
    state_d     = state_q;
    l1_rdata_d  = l1_rdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    line_we     = 1'b0;
    line_dirty  = 1'b0;
    line_data   = l1_wdata;
    dirty_clr   = 1'b0;

    case (state_q)
      IDLE: begin
        if (l1_write || l1_read) begin
          if (hit) hit_cnt_d = hit_cnt_q + 16'd1;
          else     miss_cnt_d = miss_cnt_q + 16'd1;

          if (!hit && victim_dirty) begin
            state_d     = WB;
            mem_write_d = 1'b1;
            mem_addr_d  = {tag_q[idx], idx};
            mem_wdata_d = data_q[idx];
          end else if (l1_write) begin
            // Full-line write: a clean miss installs directly, no fetch needed.
            line_we    = 1'b1;
            line_dirty = 1'b1;
            state_d    = RESP;
          end else if (hit) begin
            l1_rdata_d = data_q[idx];
            state_d    = RESP;
          end else begin
            state_d    = FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = l1_addr[29:2];
          end
        end
      end
      WB: begin
        if (mem_ready) begin
          mem_write_d = 1'b0;
          if (l1_write) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            state_d    = RESP;
          end else begin
            dirty_clr  = 1'b1;
            state_d    = FETCH;
            mem_read_d = 1'b1;
            mem_addr_d = l1_addr[29:2];
          end
        end
      end
      FETCH: begin
        if (mem_ready) begin
          mem_read_d = 1'b0;
          line_we    = 1'b1;
          line_data  = mem_rdata;
          l1_rdata_d = mem_rdata;
          state_d    = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    l1_ready_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_q     <= IDLE;
      l1_rdata_q  <= '0;
      l1_ready_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      l1_rdata_q  <= l1_rdata_d;
      l1_ready_q  <= l1_ready_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      for (int i = 0; i < ENTRYNUM; i++) begin
        valid_q[i] <= 1'b0;
        dirty_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (line_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= line_dirty;
      tag_q[idx]   <= req_tag;
      data_q[idx]  <= line_data;
    end else if (dirty_clr) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  assign l1_rdata  = l1_rdata_q;
  assign l1_ready  = l1_ready_q;
  assign l1_stall  = (l1_read | l1_write) & ~l1_ready_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule
